// File: rtl/game_ctl_multi_if.sv
// Bus between the catch-game controller and its neighbours:
// pad/spawn/button controls in, game state, score and object slots out.
interface game_ctl_multi_if #(
  parameter int N_OBJ   = 4,
  parameter int SCORE_W = 16
);
  logic                 frame_tick;
  logic                 start_btn;
  logic                 restart_btn;
  logic [11:0]          pad_x;
  logic [11:0]          spawn_x;
  logic [1:0]           state;
  logic [SCORE_W-1:0]   score;
  logic [3:0]           lives;
  logic [N_OBJ-1:0]     obj_active;
  logic [12*N_OBJ-1:0]  obj_xpos;
  logic [12*N_OBJ-1:0]  obj_ypos;
  logic                 catch_pulse;
  logic                 miss_pulse;

  modport master (
    output frame_tick, start_btn, restart_btn, pad_x, spawn_x,
    input  state, score, lives, obj_active, obj_xpos, obj_ypos, catch_pulse, miss_pulse
  );

  modport slave (
    input  frame_tick, start_btn, restart_btn, pad_x, spawn_x,
    output state, score, lives, obj_active, obj_xpos, obj_ypos, catch_pulse, miss_pulse
  );
endinterface

// File: rtl/game_ctl_multi.sv
// Catch-game control for N_OBJ falling objects: START/PLAY/END FSM, lives,
// saturating score, periodic spawning into the lowest free slot.
module game_ctl_multi #(
  parameter int N_OBJ        = 4,
  parameter int LIVES        = 3,
  parameter int SCORE_W      = 16,
  parameter int FALL_STEP    = 2,
  parameter int CATCH_Y      = 530,
  parameter int FLOOR_Y      = 600,
  parameter int OBJ_W        = 48,
  parameter int PAD_W        = 48,
  parameter int SPAWN_PERIOD = 60
) (
  input logic             pclk,
  input logic             rst,
  game_ctl_multi_if.slave bus
);
  localparam int CNT_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  // Wide enough that adding up to 8 catches can never wrap before the saturation test.
  localparam int SUM_W = ((SCORE_W > 4) ? SCORE_W : 4) + 1;
  localparam logic [11:0]      FALL_V    = 12'(FALL_STEP);
  localparam logic [11:0]      CATCH_V   = 12'(CATCH_Y);
  localparam logic [11:0]      FLOOR_V   = 12'(FLOOR_Y);
  localparam logic [12:0]      OBJ_SPAN  = 13'(OBJ_W - 1);
  localparam logic [12:0]      PAD_SPAN  = 13'(PAD_W - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SPAWN_PERIOD - 1);
  localparam logic [3:0]       LIVES_V   = 4'(LIVES);
  localparam logic [SUM_W-1:0] SCORE_MAX = SUM_W'({SCORE_W{1'b1}});

  typedef enum logic [1:0] {
    ST_START = 2'b01,
    ST_END   = 2'b10,
    ST_PLAY  = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0]         lives_q, lives_d;
  logic [N_OBJ-1:0]   act_q, act_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               catch_q, catch_d;
  logic               miss_q, miss_d;
  logic [11:0]        x_q [N_OBJ];
  logic [11:0]        x_d [N_OBJ];
  logic [11:0]        y_q [N_OBJ];
  logic [11:0]        y_d [N_OBJ];

  logic [11:0]        y_new [N_OBJ];
  logic [N_OBJ-1:0]   catch_hit, miss_hit, act_after, free_slots, spawn_oh;
  logic [3:0]         n_catch, n_miss, lives_after;
  logic [SUM_W-1:0]   score_sum;
  logic [SCORE_W-1:0] score_next;
  logic               wrap;

  for (genvar gi = 0; gi < N_OBJ; gi++) begin : g_slot
    logic [12:0] x_ext, pad_ext;
    logic        overlap;
    assign y_new[gi] = y_q[gi] + FALL_V;
    assign x_ext     = {1'b0, x_q[gi]};
    assign pad_ext   = {1'b0, bus.pad_x};
    assign overlap   = (pad_ext <= x_ext + OBJ_SPAN) && (x_ext <= pad_ext + PAD_SPAN);
    assign catch_hit[gi] = act_q[gi] && (y_q[gi] < CATCH_V) && (y_new[gi] >= CATCH_V) && overlap;
    assign miss_hit[gi]  = act_q[gi] && !catch_hit[gi] && (y_new[gi] >= FLOOR_V);
  end

  assign act_after   = act_q & ~catch_hit & ~miss_hit;
  assign free_slots  = ~act_after;
  assign spawn_oh    = free_slots & (~free_slots + N_OBJ'(1));
  assign n_catch     = 4'($countones(catch_hit));
  assign n_miss      = 4'($countones(miss_hit));
  assign score_sum   = SUM_W'(score_q) + SUM_W'(n_catch);
  assign score_next  = (score_sum > SCORE_MAX) ? '1 : score_sum[SCORE_W-1:0];
  assign lives_after = (n_miss >= lives_q) ? 4'd0 : lives_q - n_miss;
  assign wrap        = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    lives_d = lives_q;
    act_d   = act_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    catch_d = 1'b0;
    miss_d  = 1'b0;
    unique case (state_q)
      ST_START: begin
        score_d = '0;
        lives_d = LIVES_V;
        act_d   = '0;
        cnt_d   = '0;
        if (bus.start_btn) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (bus.frame_tick) begin
          catch_d = |catch_hit;
          miss_d  = |miss_hit;
          score_d = score_next;
          lives_d = lives_after;
          cnt_d   = wrap ? '0 : cnt_q + CNT_W'(1);
          act_d   = act_after;
          for (int i = 0; i < N_OBJ; i++) begin
            if (act_after[i]) y_d[i] = y_new[i];
          end
          if (lives_after == 4'd0) begin
            state_d = ST_END;
            act_d   = '0;
          end else if (wrap) begin
            // A full house leaves spawn_oh at zero, so the spawn simply drops.
            act_d = act_after | spawn_oh;
            for (int i = 0; i < N_OBJ; i++) begin
              if (spawn_oh[i]) begin
                x_d[i] = bus.spawn_x;
                y_d[i] = '0;
              end
            end
          end
        end
      end
      ST_END: begin
        act_d = '0;
        if (bus.restart_btn) begin
          state_d = ST_START;
          score_d = '0;
          lives_d = LIVES_V;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_START;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q <= ST_START;
      score_q <= '0;
      lives_q <= LIVES_V;
      act_q   <= '0;
      cnt_q   <= '0;
      catch_q <= 1'b0;
      miss_q  <= 1'b0;
      for (int i = 0; i < N_OBJ; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      lives_q <= lives_d;
      act_q   <= act_d;
      cnt_q   <= cnt_d;
      catch_q <= catch_d;
      miss_q  <= miss_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    bus.obj_xpos = '0;
    bus.obj_ypos = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      bus.obj_xpos[12*i +: 12] = x_q[i];
      bus.obj_ypos[12*i +: 12] = y_q[i];
    end
  end

  assign bus.state       = state_q;
  assign bus.score       = score_q;
  assign bus.lives       = lives_q;
  assign bus.obj_active  = act_q;
  assign bus.catch_pulse = catch_q;
  assign bus.miss_pulse  = miss_q;
endmodule

// File: tb/tb_game_ctl_multi.sv
// Scoreboard bench for game_ctl_multi: stimulus pushes hand-derived expectations,
// a negedge monitor pops and compares one entry per observed transaction.
module tb_game_ctl_multi;
  localparam int N_OBJ        = 4;
  localparam int LIVES        = 4;
  localparam int SCORE_W      = 2;
  localparam int FALL_STEP    = 2;
  localparam int CATCH_Y      = 6;
  localparam int FLOOR_Y      = 20;
  localparam int OBJ_W        = 48;
  localparam int PAD_W        = 48;
  localparam int SPAWN_PERIOD = 2;

  localparam logic [1:0] ST = 2'b01;
  localparam logic [1:0] PL = 2'b11;
  localparam logic [1:0] EN = 2'b10;

  typedef struct {
    string               name;
    logic [1:0]          st;
    logic [SCORE_W-1:0]  score;
    logic [3:0]          lives;
    logic [N_OBJ-1:0]    act;
    logic                cp;
    logic                mp;
    logic                full;
    logic [12*N_OBJ-1:0] xs;
    logic [12*N_OBJ-1:0] ys;
  } exp_t;

  logic pclk    = 1'b0;
  logic rst     = 1'b0;
  logic obs_req = 1'b0;
  logic obs_q   = 1'b0;
  logic obs_now = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  game_ctl_multi_if #(.N_OBJ(N_OBJ), .SCORE_W(SCORE_W)) bus ();

  game_ctl_multi #(
    .N_OBJ(N_OBJ), .LIVES(LIVES), .SCORE_W(SCORE_W), .FALL_STEP(FALL_STEP),
    .CATCH_Y(CATCH_Y), .FLOOR_Y(FLOOR_Y), .OBJ_W(OBJ_W), .PAD_W(PAD_W),
    .SPAWN_PERIOD(SPAWN_PERIOD)
  ) dut (
    .pclk(pclk),
    .rst (rst),
    .bus (bus)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) obs_q <= obs_req;

  task automatic check_vec(input exp_t e);
    logic bad;
    bad = 1'b0;
    vectors++;
    if (bus.state !== e.st) begin
      $display("FAIL %s state got %b want %b", e.name, bus.state, e.st); bad = 1'b1;
    end
    if (bus.score !== e.score) begin
      $display("FAIL %s score got %0d want %0d", e.name, bus.score, e.score); bad = 1'b1;
    end
    if (bus.lives !== e.lives) begin
      $display("FAIL %s lives got %0d want %0d", e.name, bus.lives, e.lives); bad = 1'b1;
    end
    if (bus.obj_active !== e.act) begin
      $display("FAIL %s obj_active got %b want %b", e.name, bus.obj_active, e.act); bad = 1'b1;
    end
    if (bus.catch_pulse !== e.cp) begin
      $display("FAIL %s catch_pulse got %b want %b", e.name, bus.catch_pulse, e.cp); bad = 1'b1;
    end
    if (bus.miss_pulse !== e.mp) begin
      $display("FAIL %s miss_pulse got %b want %b", e.name, bus.miss_pulse, e.mp); bad = 1'b1;
    end
    for (int i = 0; i < N_OBJ; i++) begin
      if (e.full || e.act[i]) begin
        if (bus.obj_xpos[12*i +: 12] !== e.xs[12*i +: 12]) begin
          $display("FAIL %s x[%0d] got %0d want %0d", e.name, i, bus.obj_xpos[12*i +: 12], e.xs[12*i +: 12]);
          bad = 1'b1;
        end
        if (bus.obj_ypos[12*i +: 12] !== e.ys[12*i +: 12]) begin
          $display("FAIL %s y[%0d] got %0d want %0d", e.name, i, bus.obj_ypos[12*i +: 12], e.ys[12*i +: 12]);
          bad = 1'b1;
        end
      end
    end
    if (bad) miscompares++;
    $display("vec %s state=%b score=%0d lives=%0d act=%b catch=%b miss=%b ypos=%h",
             e.name, bus.state, bus.score, bus.lives, bus.obj_active,
             bus.catch_pulse, bus.miss_pulse, bus.obj_ypos);
  endtask

  always @(negedge pclk) begin
    if (obs_q || obs_now) begin
      if (exp_q.size() == 0) begin
        $display("FAIL monitor scoreboard empty at time %0t got nothing want an entry", $time);
        miscompares++;
      end else begin
        check_vec(exp_q.pop_front());
      end
    end
  end

  // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
  task automatic step(input string nm, input logic tk, input logic sb, input logic rb,
                      input int pad, input int spx, input logic [1:0] st, input int sc,
                      input int lv, input logic [3:0] act, input logic cp, input logic mp,
                      input int y0, input int y1, input int y2, input int y3,
                      input int x0, input int x1, input int x2, input int x3);
    exp_t e;
    bus.frame_tick  = tk;
    bus.start_btn   = sb;
    bus.restart_btn = rb;
    bus.pad_x       = 12'(pad);
    bus.spawn_x     = 12'(spx);
    e.name  = nm;
    e.st    = st;
    e.score = SCORE_W'(sc);
    e.lives = 4'(lv);
    e.act   = act;
    e.cp    = cp;
    e.mp    = mp;
    e.full  = 1'b0;
    e.xs    = {12'(x3), 12'(x2), 12'(x1), 12'(x0)};
    e.ys    = {12'(y3), 12'(y2), 12'(y1), 12'(y0)};
    exp_q.push_back(e);
    obs_req = 1'b1;
    @(posedge pclk);
    #1;
    bus.frame_tick  = 1'b0;
    bus.start_btn   = 1'b0;
    bus.restart_btn = 1'b0;
    obs_req         = 1'b0;
  endtask

  // Asserts rst between clock edges and checks the outputs before any edge arrives.
  task automatic reset_check(input string nm);
    exp_t e;
    @(posedge pclk);
    #1 rst = 1'b1;
    e.name  = nm;
    e.st    = ST;
    e.score = '0;
    e.lives = 4'(LIVES);
    e.act   = '0;
    e.cp    = 1'b0;
    e.mp    = 1'b0;
    e.full  = 1'b1;
    e.xs    = '0;
    e.ys    = '0;
    exp_q.push_back(e);
    obs_now = 1'b1;
    @(negedge pclk);
    #1 obs_now = 1'b0;
    @(posedge pclk);
    #2 rst = 1'b0;
    @(posedge pclk);
    #1;
  endtask

  initial begin
    bus.frame_tick  = 1'b0;
    bus.start_btn   = 1'b0;
    bus.restart_btn = 1'b0;
    bus.pad_x       = 12'd200;
    bus.spawn_x     = 12'd100;

    reset_check("reset");
    step("start_tick", 1,0,0, 200,100, ST,0,4,4'b0000,0,0,  0, 0, 0, 0,   0,  0,  0,  0);
    step("start_btn",  0,1,1, 200,100, PL,0,4,4'b0000,0,0,  0, 0, 0, 0,   0,  0,  0,  0);
    step("T01",        1,0,0, 200,100, PL,0,4,4'b0000,0,0,  0, 0, 0, 0,   0,  0,  0,  0);
    step("T02",        1,0,0, 200,100, PL,0,4,4'b0001,0,0,  0, 0, 0, 0, 100,  0,  0,  0);
    step("T03",        1,0,0, 200,100, PL,0,4,4'b0001,0,0,  2, 0, 0, 0, 100,  0,  0,  0);
    step("T04",        1,0,0, 200,300, PL,0,4,4'b0011,0,0,  4, 0, 0, 0, 100,300,  0,  0);
    step("T05_catch",  1,0,0,  80,100, PL,1,4,4'b0010,1,0,  0, 2, 0, 0,   0,300,  0,  0);
    step("T06",        1,0,0, 200,100, PL,1,4,4'b0011,0,0,  0, 4, 0, 0, 100,300,  0,  0);
    step("T07",        1,0,0, 200,100, PL,1,4,4'b0011,0,0,  2, 6, 0, 0, 100,300,  0,  0);
    step("T08",        1,0,0, 200,100, PL,1,4,4'b0111,0,0,  4, 8, 0, 0, 100,300,100,  0);
    step("T09",        1,0,0, 200,100, PL,1,4,4'b0111,0,0,  6,10, 2, 0, 100,300,100,  0);
    step("T10",        1,0,0, 200,100, PL,1,4,4'b1111,0,0,  8,12, 4, 0, 100,300,100,100);
    step("T11",        1,0,0, 200,100, PL,1,4,4'b1111,0,0, 10,14, 6, 2, 100,300,100,100);
    step("T12_full",   1,0,0, 200,100, PL,1,4,4'b1111,0,0, 12,16, 8, 4, 100,300,100,100);
    step("T13_edgeR",  1,0,0, 147,100, PL,2,4,4'b0111,1,0, 14,18,10, 0, 100,300,100,  0);
    step("T14_miss",   1,0,0, 200,100, PL,2,3,4'b0111,0,1, 16, 0,12, 0, 100,100,100,  0);
    step("T15",        1,0,0, 200,100, PL,2,3,4'b0111,0,0, 18, 2,14, 0, 100,100,100,  0);
    step("T16_miss",   1,0,0, 200,100, PL,2,2,4'b0111,0,1,  0, 4,16, 0, 100,100,100,  0);
    step("T17_edgeL",  1,0,0,  53,100, PL,3,2,4'b0101,1,0,  2, 0,18, 0, 100,  0,100,  0);
    step("T18_miss",   1,0,0, 200,100, PL,3,1,4'b0011,0,1,  4, 0, 0, 0, 100,100,  0,  0);
    step("T19_sat",    1,0,0,  80,100, PL,3,1,4'b0010,1,0,  0, 2, 0, 0,   0,100,  0,  0);
    step("T20",        1,0,0, 200,100, PL,3,1,4'b0011,0,0,  0, 4, 0, 0, 100,100,  0,  0);
    step("T21_noR",    1,0,0, 148,100, PL,3,1,4'b0011,0,0,  2, 6, 0, 0, 100,100,  0,  0);
    step("T22",        1,0,0, 200,100, PL,3,1,4'b0111,0,0,  4, 8, 0, 0, 100,100,100,  0);
    step("T23_noL",    1,0,0,  52,100, PL,3,1,4'b0111,0,0,  6,10, 2, 0, 100,100,100,  0);
    step("T24",        1,0,0, 200,100, PL,3,1,4'b1111,0,0,  8,12, 4, 0, 100,100,100,100);
    step("T25",        1,0,0, 200,100, PL,3,1,4'b1111,0,0, 10,14, 6, 2, 100,100,100,100);
    step("T26_full",   1,0,0, 200,100, PL,3,1,4'b1111,0,0, 12,16, 8, 4, 100,100,100,100);
    step("T27",        1,0,0, 200,100, PL,3,1,4'b1111,0,0, 14,18,10, 6, 100,100,100,100);
    step("T28_end",    1,0,0, 200,100, EN,3,0,4'b0000,0,1,  0, 0, 0, 0,   0,  0,  0,  0);
    step("end_idle",   0,0,0, 200,100, EN,3,0,4'b0000,0,0,  0, 0, 0, 0,   0,  0,  0,  0);
    step("end_tick",   1,1,0,  80,100, EN,3,0,4'b0000,0,0,  0, 0, 0, 0,   0,  0,  0,  0);
    step("restart",    0,1,1, 200,100, ST,0,4,4'b0000,0,0,  0, 0, 0, 0,   0,  0,  0,  0);
    step("start_tk2",  1,0,0, 200,100, ST,0,4,4'b0000,0,0,  0, 0, 0, 0,   0,  0,  0,  0);
    step("start2",     0,1,0, 200,100, PL,0,4,4'b0000,0,0,  0, 0, 0, 0,   0,  0,  0,  0);
    step("P01",        1,0,0, 200,500, PL,0,4,4'b0000,0,0,  0, 0, 0, 0,   0,  0,  0,  0);
    step("P02",        1,0,0, 200,500, PL,0,4,4'b0001,0,0,  0, 0, 0, 0, 500,  0,  0,  0);
    step("P03",        1,0,0, 200,500, PL,0,4,4'b0001,0,0,  2, 0, 0, 0, 500,  0,  0,  0);
    reset_check("reset_mid");
    step("post_reset", 0,0,0, 200,100, ST,0,4,4'b0000,0,0,  0, 0, 0, 0,   0,  0,  0,  0);

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge pclk);
    if (exp_q.size() != 0) begin
      $display("FAIL drain %0d entries left want 0", exp_q.size());
      miscompares++;
    end
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
